rr_data_arbiter: RTL and testbench

Round-robin arbiter that shares one 4-bit output channel among six 4-bit data sources. Each cycle it picks one requesting source, steers its data through a 6:1 select with the encoded index, and registers the result into a single-entry valid/ready output stage. It sits between the six producer lanes and the single downstream consumer, replacing a statically driven select with fair, handshaked sharing.

---
 rtl/rr_data_arbiter.sv | 139 +++++++++++++
 tb/tb_rr_data_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_data_arbiter.sv
// rr_data_arbiter
//   Shares one DW-bit output channel among six DW-bit sources. Each cycle a
//   round-robin search picks one eligible source (req & src_en). Its data is
//   steered through a 6:1 select and captured in a single-entry valid/ready
//   output register.
//
// Ports
//   clk          rising-edge clock
//   areset_n     asynchronous active-low reset
//   req[5:0]     per-source request
//   data0..data5 per-source data, held stable while requesting and not acked
//   src_en[5:0]  enable mask; a disabled source is never granted
//   ack[5:0]     one-hot, combinational: source data is captured at this edge
//   out_valid    output register holds a word
//   out_ready    consumer accepts the word while out_valid=1
//   out_data     registered data
//   out_sel      registered index (0-5) of the producing source
//   grant_cnt    saturating count of words accepted by the consumer
module rr_data_arbiter #(
  parameter int NUM_SRC = 6,
  parameter int DW      = 4
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic [NUM_SRC-1:0]   req,
  input  logic [DW-1:0]        data0,
  input  logic [DW-1:0]        data1,
  input  logic [DW-1:0]        data2,
  input  logic [DW-1:0]        data3,
  input  logic [DW-1:0]        data4,
  input  logic [DW-1:0]        data5,
  input  logic [NUM_SRC-1:0]   src_en,
  output logic [NUM_SRC-1:0]   ack,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [2:0]           out_sel,
  output logic [7:0]           grant_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state_reg, state_next;
  logic [2:0]    ptr_reg, ptr_next;
  logic [DW-1:0] data_reg;
  logic [2:0]    sel_reg;
  logic [7:0]    cnt_reg;

  logic [NUM_SRC-1:0] elig;
  logic [2:0]         cand_idx [NUM_SRC];
  logic [NUM_SRC-1:0] cand_hit;
  logic [2:0]         win;
  logic               any_hit;
  logic [DW-1:0]      win_data;
  logic               load;
  logic               drain;

  assign elig = req & src_en;

  // Candidate gi is the source gi places after the pointer, wrapping 5 -> 0.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_cand
      logic [3:0] sum;
      assign sum          = {1'b0, ptr_reg} + 4'(gi);
      assign cand_idx[gi] = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
      assign cand_hit[gi] = elig[cand_idx[gi]];
    end
  endgenerate

  // First hit in search order wins; scan from the back so the earliest sticks.
  always_comb begin
    win     = 3'd0;
    any_hit = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        win     = cand_idx[k];
        any_hit = 1'b1;
      end
    end
  end

  // Encoded 6:1 data select; the two unused codes return zero.
  always_comb begin
    win_data = '0;
    case (win)
      3'd0:    win_data = data0;
      3'd1:    win_data = data1;
      3'd2:    win_data = data2;
      3'd3:    win_data = data3;
      3'd4:    win_data = data4;
      3'd5:    win_data = data5;
      default: win_data = '0;
    endcase
  end

  assign out_valid = (state_reg == FULL);
  assign drain     = out_valid & out_ready;
  // Gating with areset_n keeps ack low for the whole reset assertion.
  assign load      = areset_n & any_hit & (~out_valid | out_ready);
  assign ack       = load ? (NUM_SRC'(1) << win) : '0;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      EMPTY: if (load) state_next = FULL;
      FULL: begin
        if (load)           state_next = FULL;
        else if (out_ready) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
    if (load) ptr_next = (win == 3'd5) ? 3'd0 : win + 3'd1;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg <= EMPTY;
      ptr_reg   <= 3'd0;
      data_reg  <= '0;
      sel_reg   <= 3'd0;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      if (load) begin
        data_reg <= win_data;
        sel_reg  <= win;
      end
      if (drain && cnt_reg != 8'hFF) cnt_reg <= cnt_reg + 8'd1;
    end
  end

  assign out_data  = data_reg;
  assign out_sel   = sel_reg;
  assign grant_cnt = cnt_reg;

endmodule

// File: tb/tb_rr_data_arbiter.sv
module tb_rr_data_arbiter;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic [5:0] req = '0;
  logic [3:0] d [6];
  logic [5:0] src_en = '0;
  logic [5:0] ack;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [2:0] out_sel;
  logic [7:0] grant_cnt;

  int checks = 0;
  int passes = 0;

  rr_data_arbiter #(.NUM_SRC(6), .DW(4)) dut (
    .clk(clk), .areset_n(areset_n), .req(req),
    .data0(d[0]), .data1(d[1]), .data2(d[2]),
    .data3(d[3]), .data4(d[4]), .data5(d[5]),
    .src_en(src_en), .ack(ack), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: one buffered word, a pointer, a counter.
  logic       m_valid;
  logic [3:0] m_data;
  int         m_sel;
  int         m_ptr;
  int         m_cnt;
  logic [5:0] m_acked;

  function automatic int m_winner();
    for (int k = 0; k < 6; k++) begin
      int i;
      i = (m_ptr + k) % 6;
      if (req[i] && src_en[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [5:0] m_ack();
    logic [5:0] a;
    int w;
    a = '0;
    w = m_winner();
    if (areset_n && w >= 0 && !(m_valid && !out_ready)) a[w] = 1'b1;
    return a;
  endfunction

  always @(posedge clk or negedge areset_n) begin
    int w;
    logic [5:0] a;
    if (!areset_n) begin
      m_valid <= 1'b0; m_data <= 4'h0; m_sel <= 0; m_ptr <= 0; m_cnt <= 0;
      m_acked <= '0;
    end else begin
      w = m_winner();
      a = m_ack();
      m_acked <= a;
      if (m_valid && out_ready && m_cnt < 255) m_cnt <= m_cnt + 1;
      if (a != 0) begin
        m_valid <= 1'b1;
        m_data  <= d[w];
        m_sel   <= w;
        m_ptr   <= (w + 1) % 6;
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("ack", 32'(ack), 32'(m_ack()));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_sel", 32'(out_sel), 32'(m_sel));
    check("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    req = '0;
    repeat (2) tick();
    areset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 6; i++) d[i] = 4'h0;

    // Reset values
    do_reset();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_sel", 32'(out_sel), 0);
    check("rst_cnt", 32'(grant_cnt), 0);

    // Single request from source 2
    req = 6'b000100; d[2] = 4'hA; src_en = 6'h3F; out_ready = 1'b1;
    #1 check("single_ack", 32'(ack), 32'h04);
    tick();
    req = '0;
    check("single_valid", 32'(out_valid), 1);
    check("single_data", 32'(out_data), 32'hA);
    check("single_sel", 32'(out_sel), 2);
    tick();
    check("single_cnt", 32'(grant_cnt), 1);
    check("single_empty", 32'(out_valid), 0);
    $display("txn single: sel=%0d cnt=%0d", out_sel, grant_cnt);

    // All sources requesting: round-robin order
    do_reset();
    for (int i = 0; i < 6; i++) d[i] = 4'(i + 1);
    req = 6'h3F; src_en = 6'h3F; out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("rr_sel", 32'(out_sel), 32'(k % 6));
      check("rr_data", 32'(out_data), 32'((k % 6) + 1));
      $display("txn rr: sel=%0d data=%0h", out_sel, out_data);
    end
    req = '0;
    repeat (2) tick();

    // Backpressure
    do_reset();
    req = 6'h3F; out_ready = 1'b0;
    tick();
    check("bp_first_sel", 32'(out_sel), 0);
    for (int k = 0; k < 5; k++) begin
      check("bp_ack", 32'(ack), 0);
      check("bp_sel", 32'(out_sel), 0);
      check("bp_data", 32'(out_data), 1);
      tick();
    end
    out_ready = 1'b1;
    #1 check("bp_release_ack", 32'(ack), 32'h02);
    tick();
    check("bp_next_sel", 32'(out_sel), 1);
    check("bp_next_data", 32'(out_data), 2);
    $display("txn backpressure: sel=%0d data=%0h", out_sel, out_data);
    req = '0;
    repeat (2) tick();

    // Masking and wrap from ptr=5
    do_reset();
    src_en = 6'b010000; req = 6'b010000; out_ready = 1'b1;
    tick();
    check("wrap_pre_sel", 32'(out_sel), 4);
    req = 6'b100001; src_en = 6'b000001;
    #1 check("wrap_ack", 32'(ack), 32'h01);
    tick();
    check("wrap_sel", 32'(out_sel), 0);
    src_en = 6'b000000;
    #1 check("mask_ack", 32'(ack), 0);
    tick();
    check("mask_drained", 32'(out_valid), 0);
    req = 6'h3F; src_en = 6'h3F;
    #1 check("wrap_ptr1_ack", 32'(ack), 32'h02);
    $display("txn wrap: ack=%b", ack);
    tick();
    req = '0;
    repeat (2) tick();

    // Reset mid-operation
    do_reset();
    req = 6'h3F; src_en = 6'h3F; out_ready = 1'b0;
    tick();
    check("mid_loaded", 32'(out_valid), 1);
    #2 areset_n = 1'b0;
    #1;
    check("mid_valid", 32'(out_valid), 0);
    check("mid_data", 32'(out_data), 0);
    check("mid_sel", 32'(out_sel), 0);
    check("mid_cnt", 32'(grant_cnt), 0);
    check("mid_ack", 32'(ack), 0);
    $display("txn mid-reset: valid=%0d ack=%b", out_valid, ack);
    tick();
    areset_n = 1'b1;
    req = '0;
    tick();

    // Saturation
    do_reset();
    req = 6'h3F; src_en = 6'h3F; out_ready = 1'b1;
    repeat (302) tick();
    check("sat_cnt", 32'(grant_cnt), 255);
    $display("txn saturation: cnt=%0d", grant_cnt);
    req = '0;
    tick();

    // Randomized traffic with producers that hold data until acked
    do_reset();
    src_en = 6'h3F;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 6; i++) begin
        if (!req[i] || m_acked[i]) begin
          req[i] = ($urandom_range(0, 3) != 0);
          d[i]   = 4'($urandom);
        end
      end
      if ($urandom_range(0, 7) == 0) src_en = 6'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (out_valid && (c % 100 == 0))
        $display("txn rand %0d: sel=%0d data=%0h cnt=%0d", c, out_sel, out_data, grant_cnt);
    end
    req = '0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
